// File: rtl/ball_engine_if.sv
// Control and status bundle between the pong datapath and the ball engine.
// The engine takes the slave side.
interface ball_engine_if #(
  parameter int FIELD_BITS = 6
);
  logic                  tick;
  logic                  serve;
  logic [3:0]            angle;
  logic [3:0]            ball_radius;
  logic                  paddle_hit_l;
  logic                  paddle_hit_r;
  logic [FIELD_BITS-1:0] ball_x;
  logic [FIELD_BITS-1:0] ball_y;
  logic                  active;
  logic                  bounce;
  logic                  score_l;
  logic                  score_r;

  modport master (
    output tick, serve, angle, ball_radius, paddle_hit_l, paddle_hit_r,
    input  ball_x, ball_y, active, bounce, score_l, score_r
  );

  modport slave (
    input  tick, serve, angle, ball_radius, paddle_hit_l, paddle_hit_r,
    output ball_x, ball_y, active, bounce, score_l, score_r
  );
endinterface

// File: rtl/ball_engine.sv
// Fixed-point ball motion engine: serve/launch FSM, per-frame motion,
// wall and paddle reflection, and miss detection with score pulses.
module ball_engine #(
  parameter int FIELD_BITS  = 6,
  parameter int FRAC_BITS   = 4,
  parameter int SERVE_DELAY = 64
) (
  input  logic         clk,
  input  logic         reset,
  ball_engine_if.slave bus
);

  localparam int POS_W = FIELD_BITS + FRAC_BITS;
  localparam int VEL_W = FRAC_BITS + 4;
  localparam int SUM_W = POS_W + 2;
  localparam int EXT_W = FIELD_BITS + 5;
  localparam int CNT_W = $clog2(SERVE_DELAY + 1);

  localparam logic [POS_W-1:0] CENTER    = {1'b1, {(POS_W-1){1'b0}}};
  localparam logic [POS_W-1:0] POS_MAX   = {POS_W{1'b1}};
  localparam logic [EXT_W-1:0] FIELD_MAX = EXT_W'((1 << FIELD_BITS) - 1);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(SERVE_DELAY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_MOVE
  } state_t;

  typedef struct packed {
    logic signed [7:0] vx;
    logic signed [7:0] vy;
  } launch_t;

  // Launch velocities at 4 fraction bits; angle 6 is straight down and
  // could never reach a scoring edge, so it reuses angle 5.
  function automatic launch_t launch_lookup(input logic [3:0] idx);
    launch_t e;
    case (idx)
      4'd0:        begin e.vx =  8'sd16; e.vy =  8'sd0;  end
      4'd1:        begin e.vx =  8'sd15; e.vy =  8'sd6;  end
      4'd2:        begin e.vx =  8'sd14; e.vy =  8'sd8;  end
      4'd3:        begin e.vx =  8'sd11; e.vy =  8'sd11; end
      4'd4:        begin e.vx =  8'sd8;  e.vy =  8'sd14; end
      4'd5, 4'd6:  begin e.vx =  8'sd6;  e.vy =  8'sd15; end
      4'd7:        begin e.vx = -8'sd6;  e.vy =  8'sd15; end
      4'd8:        begin e.vx = -8'sd8;  e.vy =  8'sd14; end
      4'd9:        begin e.vx = -8'sd11; e.vy =  8'sd11; end
      4'd10:       begin e.vx = -8'sd14; e.vy =  8'sd8;  end
      4'd11:       begin e.vx = -8'sd15; e.vy =  8'sd6;  end
      4'd12:       begin e.vx = -8'sd16; e.vy =  8'sd0;  end
      4'd13:       begin e.vx = -8'sd15; e.vy = -8'sd6;  end
      4'd14:       begin e.vx = -8'sd14; e.vy = -8'sd8;  end
      default:     begin e.vx = -8'sd11; e.vy = -8'sd11; end
    endcase
    return e;
  endfunction

  function automatic logic signed [VEL_W-1:0] scale_vel(input logic signed [7:0] v);
    logic signed [VEL_W-1:0] ext;
    ext = VEL_W'(v);
    return ext <<< (FRAC_BITS - 4);
  endfunction

  // Position moves are clamped to the register range rather than wrapping.
  function automatic logic [POS_W-1:0] sat_add(input logic [POS_W-1:0]        p,
                                               input logic signed [VEL_W-1:0] v);
    logic signed [SUM_W-1:0] sum;
    sum = $signed({2'b00, p}) + SUM_W'(v);
    if (sum[SUM_W-1])
      return '0;
    else if (sum[SUM_W-2])
      return POS_MAX;
    else
      return sum[POS_W-1:0];
  endfunction

  state_t                  state_q, state_d;
  logic [POS_W-1:0]        pos_x_q, pos_x_d, pos_y_q, pos_y_d;
  logic signed [VEL_W-1:0] vel_x_q, vel_x_d, vel_y_q, vel_y_d;
  logic [CNT_W-1:0]        wait_q, wait_d;
  logic                    active_q, bounce_q, bounce_d;
  logic                    score_l_q, score_l_d, score_r_q, score_r_d;

  launch_t                 launch;
  logic [EXT_W-1:0]        cur_x, cur_y, radius;
  logic                    vx_neg, vx_pos, vy_neg, vy_pos;
  logic                    at_left, at_right, at_top, at_bottom;
  logic                    miss_l, miss_r, hit_x;

  assign launch = launch_lookup(bus.angle);
  assign cur_x  = EXT_W'(pos_x_q[POS_W-1:FRAC_BITS]);
  assign cur_y  = EXT_W'(pos_y_q[POS_W-1:FRAC_BITS]);
  assign radius = EXT_W'(bus.ball_radius);

  assign vx_neg = vel_x_q[VEL_W-1];
  assign vx_pos = !vel_x_q[VEL_W-1] && (vel_x_q != '0);
  assign vy_neg = vel_y_q[VEL_W-1];
  assign vy_pos = !vel_y_q[VEL_W-1] && (vel_y_q != '0);

  // Edge tests only fire while moving toward the edge, so a ball still
  // inside the margin after a flip is left alone.
  assign at_left   = (cur_x <= radius) && vx_neg;
  assign at_right  = ((cur_x + radius) >= FIELD_MAX) && vx_pos;
  assign at_top    = (cur_y <= radius) && vy_neg;
  assign at_bottom = ((cur_y + radius) >= FIELD_MAX) && vy_pos;

  assign miss_l = at_left && !bus.paddle_hit_l;
  assign miss_r = at_right && !bus.paddle_hit_r;
  assign hit_x  = (at_left && bus.paddle_hit_l) || (at_right && bus.paddle_hit_r);

  always_comb begin
    state_d   = state_q;
    pos_x_d   = pos_x_q;
    pos_y_d   = pos_y_q;
    vel_x_d   = vel_x_q;
    vel_y_d   = vel_y_q;
    wait_d    = wait_q;
    bounce_d  = 1'b0;
    score_l_d = 1'b0;
    score_r_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        pos_x_d = CENTER;
        pos_y_d = CENTER;
        vel_x_d = '0;
        vel_y_d = '0;
        if (bus.serve) begin
          vel_x_d = scale_vel(launch.vx);
          vel_y_d = scale_vel(launch.vy);
          wait_d  = '0;
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.tick) begin
          if (wait_q == WAIT_LAST) begin
            wait_d  = '0;
            state_d = ST_MOVE;
          end else begin
            wait_d = wait_q + CNT_W'(1);
          end
        end
      end

      ST_MOVE: begin
        if (bus.tick) begin
          // A miss wins over everything else on the same tick.
          if (miss_l || miss_r) begin
            state_d   = ST_IDLE;
            pos_x_d   = CENTER;
            pos_y_d   = CENTER;
            vel_x_d   = '0;
            vel_y_d   = '0;
            score_l_d = miss_r;
            score_r_d = miss_l;
          end else begin
            pos_x_d = sat_add(pos_x_q, vel_x_q);
            pos_y_d = sat_add(pos_y_q, vel_y_q);
            if (hit_x) begin
              vel_x_d  = -vel_x_q;
              bounce_d = 1'b1;
            end
            if (at_top || at_bottom) begin
              vel_y_d  = -vel_y_q;
              bounce_d = 1'b1;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      pos_x_q   <= CENTER;
      pos_y_q   <= CENTER;
      vel_x_q   <= '0;
      vel_y_q   <= '0;
      wait_q    <= '0;
      active_q  <= 1'b0;
      bounce_q  <= 1'b0;
      score_l_q <= 1'b0;
      score_r_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pos_x_q   <= pos_x_d;
      pos_y_q   <= pos_y_d;
      vel_x_q   <= vel_x_d;
      vel_y_q   <= vel_y_d;
      wait_q    <= wait_d;
      active_q  <= (state_d == ST_MOVE);
      bounce_q  <= bounce_d;
      score_l_q <= score_l_d;
      score_r_q <= score_r_d;
    end
  end

  assign bus.ball_x  = pos_x_q[POS_W-1:FRAC_BITS];
  assign bus.ball_y  = pos_y_q[POS_W-1:FRAC_BITS];
  assign bus.active  = active_q;
  assign bus.bounce  = bounce_q;
  assign bus.score_l = score_l_q;
  assign bus.score_r = score_r_q;

endmodule

// File: tb/tb_ball_engine.sv
// Directed bench for ball_engine: idle hold, serve timing, wall and paddle
// reflection, miss scoring, reset mid-flight and tick gating.
module tb_ball_engine;

  localparam int FIELD_BITS  = 6;
  localparam int FRAC_BITS   = 4;
  localparam int SERVE_DELAY = 4;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  ball_engine_if #(.FIELD_BITS(FIELD_BITS)) bif ();

  ball_engine #(
    .FIELD_BITS (FIELD_BITS),
    .FRAC_BITS  (FRAC_BITS),
    .SERVE_DELAY(SERVE_DELAY)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bif)
  );

  always #5 clk = ~clk;

  task automatic applyStimulus(input logic t);
    bif.tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, actual, expected);
    end
  endtask

  task automatic resetDut();
    reset = 1'b1;
    applyStimulus(1'b0);
    reset = 1'b0;
  endtask

  // Serve is accepted on one edge, then SERVE_DELAY ticks bring up MOVE.
  task automatic serveBall(input logic [3:0] a);
    bif.serve = 1'b1;
    bif.angle = a;
    applyStimulus(1'b0);
    bif.serve = 1'b0;
    repeat (SERVE_DELAY) applyStimulus(1'b1);
  endtask

  initial begin
    reset            = 1'b1;
    bif.tick         = 1'b0;
    bif.serve        = 1'b0;
    bif.angle        = 4'd0;
    bif.ball_radius  = 4'd2;
    bif.paddle_hit_l = 1'b0;
    bif.paddle_hit_r = 1'b0;
    repeat (2) applyStimulus(1'b0);
    reset = 1'b0;

    $display("[TB] reset and idle");
    checkOutput("rst_x", bif.ball_x, 32);
    checkOutput("rst_y", bif.ball_y, 32);
    checkOutput("rst_active", bif.active, 0);
    checkOutput("rst_bounce", bif.bounce, 0);
    checkOutput("rst_score", {bif.score_l, bif.score_r}, 0);
    for (int i = 0; i < 8; i++) begin
      applyStimulus(logic'(i % 2));
      checkOutput("idle_x", bif.ball_x, 32);
      checkOutput("idle_y", bif.ball_y, 32);
      checkOutput("idle_active", bif.active, 0);
      checkOutput("idle_pulses", {bif.bounce, bif.score_l, bif.score_r}, 0);
    end

    $display("[TB] serve angle 0");
    bif.serve = 1'b1;
    bif.angle = 4'd0;
    applyStimulus(1'b0);
    bif.serve = 1'b0;
    checkOutput("wait_active0", bif.active, 0);
    repeat (SERVE_DELAY - 1) applyStimulus(1'b1);
    checkOutput("wait_active3", bif.active, 0);
    applyStimulus(1'b1);
    checkOutput("move_active", bif.active, 1);
    checkOutput("move_x0", bif.ball_x, 32);
    for (int k = 1; k <= 3; k++) begin
      applyStimulus(1'b1);
      checkOutput("move_x", bif.ball_x, 32 + k);
      checkOutput("move_y", bif.ball_y, 32);
    end
    bif.serve = 1'b1;
    bif.angle = 4'd12;
    applyStimulus(1'b1);
    bif.serve = 1'b0;
    checkOutput("serve_in_move_x", bif.ball_x, 36);
    applyStimulus(1'b1);
    checkOutput("serve_in_move_dir", bif.ball_x, 37);
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b0);
      checkOutput("frozen_x", bif.ball_x, 37);
      checkOutput("frozen_bounce", bif.bounce, 0);
    end
    applyStimulus(1'b1);
    checkOutput("resume_x", bif.ball_x, 38);

    $display("[TB] reset mid-move");
    reset = 1'b1;
    applyStimulus(1'b1);
    reset = 1'b0;
    checkOutput("midrst_x", bif.ball_x, 32);
    checkOutput("midrst_y", bif.ball_y, 32);
    checkOutput("midrst_active", bif.active, 0);
    checkOutput("midrst_pulses", {bif.bounce, bif.score_l, bif.score_r}, 0);
    applyStimulus(1'b1);
    checkOutput("midrst_idle_x", bif.ball_x, 32);
    checkOutput("midrst_idle_active", bif.active, 0);

    $display("[TB] angle 3 bottom wall with right paddle");
    bif.paddle_hit_r = 1'b1;
    serveBall(4'd3);
    repeat (43) applyStimulus(1'b1);
    checkOutput("a3_pre_x", bif.ball_x, 61);
    checkOutput("a3_pre_y", bif.ball_y, 61);
    checkOutput("a3_pre_bounce", bif.bounce, 0);
    applyStimulus(1'b1);
    checkOutput("a3_bounce", bif.bounce, 1);
    checkOutput("a3_flip_y", bif.ball_y, 62);
    checkOutput("a3_flip_x", bif.ball_x, 62);
    checkOutput("a3_no_score", bif.score_l, 0);
    checkOutput("a3_active", bif.active, 1);
    applyStimulus(1'b1);
    checkOutput("a3_post_bounce", bif.bounce, 0);
    checkOutput("a3_post_y1", bif.ball_y, 61);
    applyStimulus(1'b1);
    checkOutput("a3_post_y2", bif.ball_y, 60);
    checkOutput("a3_post_x2", bif.ball_x, 60);
    checkOutput("a3_no_reflip", bif.bounce, 0);
    resetDut();

    $display("[TB] angle 3 miss on right with wall on same tick");
    bif.paddle_hit_r = 1'b0;
    serveBall(4'd3);
    repeat (43) applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("miss_r_score_l", bif.score_l, 1);
    checkOutput("miss_r_bounce", bif.bounce, 0);
    checkOutput("miss_r_active", bif.active, 0);
    checkOutput("miss_r_x", bif.ball_x, 32);
    checkOutput("miss_r_y", bif.ball_y, 32);
    applyStimulus(1'b1);
    checkOutput("miss_r_pulse_end", bif.score_l, 0);

    $display("[TB] angle 12 left miss");
    serveBall(4'd12);
    repeat (30) applyStimulus(1'b1);
    checkOutput("a12_pre_x", bif.ball_x, 2);
    checkOutput("a12_pre_score", bif.score_r, 0);
    applyStimulus(1'b1);
    checkOutput("a12_score_r", bif.score_r, 1);
    checkOutput("a12_score_l", bif.score_l, 0);
    checkOutput("a12_active", bif.active, 0);
    checkOutput("a12_x", bif.ball_x, 32);
    checkOutput("a12_y", bif.ball_y, 32);
    applyStimulus(1'b1);
    checkOutput("a12_pulse_end", bif.score_r, 0);
    serveBall(4'd0);
    checkOutput("relaunch_active", bif.active, 1);
    applyStimulus(1'b1);
    checkOutput("relaunch_x", bif.ball_x, 33);
    resetDut();

    $display("[TB] angle 12 left paddle hit");
    serveBall(4'd12);
    repeat (30) applyStimulus(1'b1);
    bif.paddle_hit_l = 1'b1;
    applyStimulus(1'b1);
    bif.paddle_hit_l = 1'b0;
    checkOutput("paddle_bounce", bif.bounce, 1);
    checkOutput("paddle_no_score", bif.score_r, 0);
    checkOutput("paddle_active", bif.active, 1);
    checkOutput("paddle_x", bif.ball_x, 1);
    applyStimulus(1'b1);
    checkOutput("paddle_ret_x1", bif.ball_x, 2);
    checkOutput("paddle_bounce_end", bif.bounce, 0);
    applyStimulus(1'b1);
    checkOutput("paddle_ret_x2", bif.ball_x, 3);
    resetDut();

    $display("[TB] angle 6 substitution");
    serveBall(4'd6);
    repeat (16) applyStimulus(1'b1);
    checkOutput("a6_x", bif.ball_x, 38);
    checkOutput("a6_y", bif.ball_y, 47);
    checkOutput("a6_active", bif.active, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball motion engine for the pong datapath; successor to the fixed 64×64 ball block. Adds a serve/launch state machine, a frame-tick enable, configurable field size and fixed-point precision, and paddle-aware left/right edges with miss/score events. It sits between the collision/paddle logic, which supplies the hit strobes, and the renderer/score logic, which consume position, `bounce` and the score pulses.

## Interface
Parameters:
- `FIELD_BITS`, 6: integer coordinate width; the field spans 0..2^FIELD_BITS−1 on both axes.
- `FRAC_BITS`, 4: fraction bits of position and velocity; legal range ≥4.
- `SERVE_DELAY`, 64: number of `tick` strobes spent in WAIT before motion starts; legal range ≥1.

Ports:
- `clk`, in, 1: single clock.
- `reset`, in, 1: synchronous, active-high.
- `tick`, in, 1: frame update strobe; position and velocity change only on cycles where `tick`=1.
- `serve`, in, 1: launch request; honoured only in IDLE.
- `angle`, in, 4: launch direction index; latched when `serve` is accepted.
- `ball_radius`, in, 4: edge margin in pixels.
- `paddle_hit_l`, in, 1: left paddle covers the ball; sampled on `tick`.
- `paddle_hit_r`, in, 1: right paddle covers the ball; sampled on `tick`.
- `ball_x`, out, FIELD_BITS: integer part of the X position.
- `ball_y`, out, FIELD_BITS: integer part of the Y position.
- `active`, out, 1: high while in MOVE.
- `bounce`, out, 1: one-cycle pulse on any wall or paddle reflection.
- `score_l`, out, 1: one-cycle pulse when the ball exits the right edge (left player scores).
- `score_r`, out, 1: one-cycle pulse when the ball exits the left edge (right player scores).

## Operation
- Position registers are `FIELD_BITS+FRAC_BITS` wide, unsigned. Velocity registers are `FRAC_BITS+4` wide, signed.
- CENTER = 2^(FIELD_BITS−1) << FRAC_BITS. MAX = 2^FIELD_BITS − 1, in integer pixels.
- Launch table, indexed by angle, gives (vx, vy) at FRAC_BITS=4. For larger FRAC_BITS, shift each value left by FRAC_BITS−4.
  - 0:(16,0) 1:(15,6) 2:(14,8) 3:(11,11) 4:(8,14) 5:(6,15) 6:(0,16)
  - 7:(−6,15) 8:(−8,14) 9:(−11,11) 10:(−14,8) 11:(−15,6) 12:(−16,0)
  - 13:(−15,−6) 14:(−14,−8) 15:(−11,−11)
  - Angle 6 has vx=0 and would never score, so it is substituted with angle 5.
- State machine: IDLE → WAIT → MOVE → IDLE.
  - IDLE: ball held at (CENTER, CENTER), velocity 0. `serve`=1 latches the velocity from the table and enters WAIT.
  - WAIT: a counter is cleared on entry and increments on each `tick`. The SERVE_DELAY-th tick causes a transition to MOVE; that tick moves nothing.
  - MOVE: on each `tick`, the following apply together, all decisions using the pre-update integer position and velocity sign:
    - Position update: pos += v, saturating at 0 and at 2^(FIELD_BITS+FRAC_BITS)−1. It never wraps.
    - Top wall: ball_y ≤ radius and vy<0 → vy := −vy. Bottom wall: ball_y ≥ MAX−radius and vy>0 → vy := −vy.
    - Left edge: ball_x ≤ radius and vx<0. If `paddle_hit_l`=1 → vx := −vx. Otherwise → `score_r` pulse, enter IDLE, position reset to center.
    - Right edge: ball_x ≥ MAX−radius and vx>0. Symmetric, using `paddle_hit_r` and `score_l`.
    - `bounce` pulses when any reflection occurs on that tick.
  - Reflections are direction-qualified: a ball that is still inside the margin after a flip is never flipped back.
- Priority: reset > miss/score > paddle reflection > wall reflection. An X miss and a Y wall on the same tick → score only; the Y flip is discarded.
- Paddle hit strobes are ignored when the ball is not at the matching edge or is moving away from it.
- `serve` is ignored outside IDLE. `angle` changes after latch have no effect.

## Timing
- Reset values: state IDLE; ball_x = ball_y = 2^(FIELD_BITS−1); vx = vy = 0; `active`, `bounce`, `score_l`, `score_r` = 0; WAIT counter = 0.
- Reset mid-WAIT or mid-MOVE: all of the above take effect on the next edge; no score pulse is generated.
- All outputs are registered.
- `serve` accepted at edge n → WAIT visible at n+1.
- The SERVE_DELAY-th tick at edge m → `active`=1 from m+1. The first position change occurs on the next tick after that.
- Update latency: a tick at edge n → new ball_x/ball_y visible after edge n.
- `bounce` and the score pulses are high for exactly the cycle following the deciding tick, and are 0 on every non-tick cycle.
- `tick`=0 holds position, velocity, state and the WAIT counter.

## Test plan
- Reset, then idle with `tick` toggling → ball_x = ball_y = 32, `active`=0, no pulses; a position change at any point is a failure.
- SERVE_DELAY=4, `tick` every cycle, `serve` with angle 0 → `active` rises after the 4th tick; ball_x then increases by 1 per tick (33, 34, …) and ball_y stays at 32.
- angle=3, radius=2: let the ball reach ball_y ≥ 61 → vy becomes −11 on that tick, `bounce` pulses for one cycle, and ball_y decreases on subsequent ticks with no second flip.
- angle=12, `paddle_hit_l`=0, radius=2: at the tick where ball_x ≤ 2 → `score_r` for one cycle, `active`=0, ball back at (32,32). `serve` then relaunches.
- Same as the previous case but with `paddle_hit_l`=1 on the edge tick → vx=+16, `bounce` pulse, no `score_r`. Bonus check: angle 6 launches with (6,15).
- `reset` asserted mid-MOVE → all reset values on the next cycle. `serve` pulsed during MOVE → no effect. `tick` held 0 for 10 cycles → position frozen.
